// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants and types for the accumulator CPU front end.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int OPC_W   = 5;
  localparam int MODE_W  = 3;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = OPC_W + MODE_W + DATA_W;

  // Opcode that stops the fetch engine; all ones of the opcode field.
  localparam logic [OPC_W-1:0] HALT_OPC = {OPC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Instruction word layout, MSB first.
  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
  } instr_t;

endpackage

// File: rtl/instr_ram.sv
// Instruction store: one synchronous write port for program load and one
// registered read port with read enable. Contents survive reset.
module instr_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write and registered read; rdata holds whenever the read is not enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, fetch FSM, request tracking and the
// fetch/decode stage register around a synchronous instruction RAM.
//
// state | meaning
// IDLE  | not fetching; program load allowed; pc retained
// FETCH | issuing one read per unstalled cycle, staging returned words
// HALT  | halt opcode captured; waits for a branch; program load allowed
module instr_fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int OPC_W  = cpu_pkg::OPC_W,
  parameter int MODE_W = cpu_pkg::MODE_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter logic [OPC_W-1:0] HALT_OPC = {OPC_W{1'b1}}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run,
  input  logic                            stall,
  input  logic                            branch_valid,
  input  logic [ADDR_W-1:0]               branch_target,
  input  logic                            prog_we,
  input  logic [ADDR_W-1:0]               prog_addr,
  input  logic [OPC_W+MODE_W+DATA_W-1:0]  prog_wdata,
  output logic [ADDR_W-1:0]               pc,
  output logic [OPC_W-1:0]                instr_opc,
  output logic [MODE_W-1:0]               instr_mode,
  output logic [DATA_W-1:0]               instr_data,
  output logic [ADDR_W-1:0]               instr_pc,
  output logic                            instr_valid,
  output logic                            halted,
  output logic                            busy
);

  import cpu_pkg::*;

  localparam int INSTR_W = OPC_W + MODE_W + DATA_W;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;

  logic               ram_re;
  logic               ram_we;
  logic [INSTR_W-1:0] ram_rdata;
  logic [OPC_W-1:0]   rd_opc;
  logic [MODE_W-1:0]  rd_mode;
  logic [DATA_W-1:0]  rd_data;

  // Loading the program while fetching would race the read path, so it is
  // only accepted outside FETCH.
  assign ram_we = prog_we && (state_q != FETCH);

  instr_ram #(
    .AW (ADDR_W),
    .DW (INSTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_wdata),
    .re_i    (ram_re),
    .raddr_i (pc_q),
    .rdata_o (ram_rdata)
  );

  assign rd_opc  = ram_rdata[INSTR_W-1 -: OPC_W];
  assign rd_mode = ram_rdata[DATA_W +: MODE_W];
  assign rd_data = ram_rdata[DATA_W-1:0];

  // Next-state logic: branch beats run-drop, stall and halt detection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_valid_d   = req_valid_q;
    req_pc_d      = req_pc_q;
    opc_d         = opc_q;
    mode_d        = mode_q;
    data_d        = data_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    ram_re        = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (branch_valid) begin
          pc_d          = branch_target;
          req_valid_d   = 1'b0;
          instr_valid_d = 1'b0;
          if (!run) begin
            state_d = IDLE;
          end
        end else if (!run) begin
          state_d       = IDLE;
          req_valid_d   = 1'b0;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          if (req_valid_q && (rd_opc == HALT_OPC)) begin
            // pc already points past the halt word; no new read is issued.
            state_d       = HALT;
            halted_d      = 1'b1;
            req_valid_d   = 1'b0;
            instr_valid_d = 1'b0;
          end else begin
            ram_re      = 1'b1;
            pc_d        = pc_q + ADDR_W'(1);
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            if (req_valid_q) begin
              opc_d         = rd_opc;
              mode_d        = rd_mode;
              data_d        = rd_data;
              instr_pc_d    = req_pc_q;
              instr_valid_d = 1'b1;
            end
          end
        end
      end

      HALT: begin
        if (branch_valid) begin
          state_d       = FETCH;
          pc_d          = branch_target;
          halted_d      = 1'b0;
          req_valid_d   = 1'b0;
          instr_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC, request and stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      req_valid_q   <= 1'b0;
      req_pc_q      <= '0;
      opc_q         <= '0;
      mode_q        <= '0;
      data_q        <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      opc_q         <= opc_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign instr_opc   = opc_q;
  assign instr_mode  = mode_q;
  assign instr_data  = data_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign busy        = (state_q == FETCH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_instr_fetch_unit;

  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                run = 1'b0;
  logic                stall = 1'b0;
  logic                branch_valid = 1'b0;
  logic [ADDR_W-1:0]   branch_target = '0;
  logic                prog_we = 1'b0;
  logic [ADDR_W-1:0]   prog_addr = '0;
  logic [INSTR_W-1:0]  prog_wdata = '0;
  logic [ADDR_W-1:0]   pc;
  logic [OPC_W-1:0]    instr_opc;
  logic [MODE_W-1:0]   instr_mode;
  logic [DATA_W-1:0]   instr_data;
  logic [ADDR_W-1:0]   instr_pc;
  logic                instr_valid;
  logic                halted;
  logic                busy;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_wdata    (prog_wdata),
    .pc            (pc),
    .instr_opc     (instr_opc),
    .instr_mode    (instr_mode),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: program image, fetch mode, and a queue of addresses
  // whose read has been issued but not yet delivered.
  instr_t      mem_m [2**ADDR_W];
  int          m_mode = 0;          // 0 idle, 1 fetching, 2 halted
  int          m_pc = 0;
  int          pend[$];
  instr_t      m_stage = '0;
  int          m_ipc = 0;
  bit          m_valid = 1'b0;
  bit          m_halted = 1'b0;

  task automatic model_edge();
    if (prog_we && m_mode != 1) mem_m[prog_addr] = instr_t'(prog_wdata);
    if (rst) begin
      m_mode = 0; m_pc = 0; pend.delete(); m_stage = '0;
      m_ipc = 0; m_valid = 0; m_halted = 0;
    end else if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (branch_valid) begin
        m_pc = int'(branch_target); pend.delete(); m_valid = 0;
        if (!run) m_mode = 0;
      end else if (!run) begin
        m_mode = 0; pend.delete(); m_valid = 0;
      end else if (!stall) begin
        if (pend.size() > 0 && mem_m[pend[0]].opc == HALT_OPC) begin
          m_mode = 2; m_halted = 1; m_valid = 0; pend.delete();
        end else begin
          if (pend.size() > 0) begin
            m_stage = mem_m[pend[0]]; m_ipc = pend[0]; m_valid = 1;
          end
          pend.delete();
          pend.push_back(m_pc);
          m_pc = (m_pc + 1) % (2**ADDR_W);
        end
      end
    end else begin
      if (branch_valid) begin
        m_pc = int'(branch_target); m_halted = 0; m_mode = 1;
      end
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later,
  // single-cycle strobes dropped afterwards.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("pc", pc, m_pc);
    check("valid", instr_valid, m_valid);
    check("halted", halted, m_halted);
    check("busy", busy, (m_mode == 1));
    check("opc", instr_opc, m_stage.opc);
    check("mode", instr_mode, m_stage.mode);
    check("data", instr_data, m_stage.data);
    check("ipc", instr_pc, m_ipc);
    rst = 1'b0; branch_valid = 1'b0; prog_we = 1'b0;
  endtask

  function automatic instr_t init_word(input int a);
    instr_t w;
    if (a < 4) begin
      w.opc = OPC_W'(a + 1); w.mode = '0; w.data = DATA_W'(8'h10 + a);
    end else if (a == 8'h40) begin
      w.opc = 5'h07; w.mode = 3'h2; w.data = 8'hA5;
    end else begin
      w.opc = OPC_W'($urandom_range(0, 30));
      w.mode = MODE_W'($urandom); w.data = DATA_W'($urandom);
    end
    return w;
  endfunction

  instr_t w;
  int     a_we;
  instr_t orig;

  initial begin
    // Reset
    rst = 1'b1; cyc();
    check("rst_pc", pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);

    // Program load in IDLE
    for (int a = 0; a < 2**ADDR_W; a++) begin
      w = init_word(a);
      prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_wdata = w; cyc();
    end

    // Start-up latency and streaming
    run = 1'b1; cyc();
    check("lat_e0_valid", instr_valid, 0);
    cyc();
    check("lat_e1_valid", instr_valid, 0);
    cyc();
    check("lat_e2_valid", instr_valid, 1);
    check("lat_e2_opc", instr_opc, 1);
    check("lat_e2_ipc", instr_pc, 0);
    cyc();
    check("stream_opc2", instr_opc, 2);

    // Stall for 3 cycles on opc 2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_opc", instr_opc, 2);
      check("stall_pc", pc, 3);
      check("stall_valid", instr_valid, 1);
    end
    stall = 1'b0; cyc();
    check("unstall_opc3", instr_opc, 3);
    cyc();
    check("unstall_opc4", instr_opc, 4);

    // Branch while running
    branch_valid = 1'b1; branch_target = 8'h40; cyc();
    check("br_flush0", instr_valid, 0);
    cyc();
    check("br_flush1", instr_valid, 0);
    cyc();
    check("br_opc", instr_opc, 7);
    check("br_ipc", instr_pc, 8'h40);

    // Branch together with stall still redirects
    stall = 1'b1; branch_valid = 1'b1; branch_target = 8'h40; cyc();
    check("brst_pc", pc, 8'h40);
    check("brst_valid", instr_valid, 0);
    stall = 1'b0; cyc(); cyc();
    check("brst_opc", instr_opc, 7);

    // Halt opcode at word 2
    run = 1'b0; cyc();
    w = '0; w.opc = HALT_OPC;
    prog_we = 1'b1; prog_addr = 8'd2; prog_wdata = w; cyc();
    rst = 1'b1; cyc();
    run = 1'b1; cyc(); cyc(); cyc(); cyc();
    check("halt_pre_opc", instr_opc, 2);
    cyc();
    check("halt_flag", halted, 1);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc, 3);
    cyc(); cyc();
    check("halt_pc_hold", pc, 3);
    w = init_word(2);
    prog_we = 1'b1; prog_addr = 8'd2; prog_wdata = w; cyc();
    branch_valid = 1'b1; branch_target = 8'h00; cyc();
    check("halt_exit", halted, 0);
    cyc(); cyc();
    check("resume_opc", instr_opc, 1);
    check("resume_ipc", instr_pc, 0);

    // PC wrap-around
    branch_valid = 1'b1; branch_target = 8'hFE; cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("wrap_ipc", instr_pc, (8'hFE + i) % 256);
    end

    // Program write during FETCH is ignored
    a_we = int'(pc);
    orig = mem_m[a_we];
    w.opc = 5'h1E; w.mode = 3'h7; w.data = 8'hFF;
    if (orig.opc == 5'h1E) w.opc = 5'h1D;
    prog_we = 1'b1; prog_addr = ADDR_W'(a_we); prog_wdata = w; cyc();
    branch_valid = 1'b1; branch_target = ADDR_W'(a_we); cyc(); cyc(); cyc();
    check("we_ignored_opc", instr_opc, orig.opc);

    // Reset in the middle of a run
    rst = 1'b1; cyc();
    check("mrst_pc", pc, 0);
    check("mrst_valid", instr_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_opc", instr_opc, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      run           = ($urandom_range(0, 19) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_valid  = ($urandom_range(0, 9) == 0);
      branch_target = ADDR_W'($urandom);
      prog_we       = ($urandom_range(0, 7) == 0);
      prog_addr     = ADDR_W'($urandom);
      prog_wdata    = INSTR_W'($urandom);
      rst           = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
